// File: rtl/inst_fetch_queue.sv
// Instruction-fetch initiator: issues word fetches to the MC and queues {inst, pc} pairs for decode.
// A redirect flushes the queue; a fetch already issued to the MC is squashed on return.
module inst_fetch_queue #(
   parameter int          QUEUE_LOG = 3,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   output logic        inst_IF_req,
   output logic [31:0] inst_IF_addr,
   input  logic        inst_IF_flag,
   input  logic [31:0] inst_IF,
   input  logic        jump_flag,
   input  logic [31:0] jump_pc,
   input  logic        deq_ready,
   output logic        deq_valid,
   output logic [31:0] deq_inst,
   output logic [31:0] deq_pc,
   output logic        queue_full
);
   localparam int DEPTH = 1 << QUEUE_LOG;

   typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

   state_t                state, state_nxt;
   logic [31:0]           pc, pc_nxt, addr_nxt, jump_tgt;
   logic                  req_nxt, push, pop, flush, room;
   logic [QUEUE_LOG-1:0]  head, tail;
   logic [QUEUE_LOG:0]    count;
   logic [31:0]           inst_mem [DEPTH];
   logic [31:0]           pc_mem   [DEPTH];

   assign jump_tgt   = {jump_pc[31:2], 2'b00};
   assign room       = count < (QUEUE_LOG+1)'(DEPTH);
   assign deq_valid  = count != '0;
   assign queue_full = count == (QUEUE_LOG+1)'(DEPTH);
   assign deq_inst   = inst_mem[head];
   assign deq_pc     = pc_mem[head];
   assign flush      = rdy & jump_flag;
   // A redirect wins over a same-cycle pop.
   assign pop        = rdy & deq_valid & deq_ready & ~jump_flag;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      addr_nxt  = inst_IF_addr;
      req_nxt   = inst_IF_req;
      push      = 1'b0;
      if (rdy) begin
         case (state)
            IDLE: begin
               if (jump_flag) begin
                  pc_nxt = jump_tgt;
               end else if (room) begin
                  addr_nxt  = pc;
                  req_nxt   = 1'b1;
                  state_nxt = FETCH;
               end
            end
            FETCH: begin
               if (inst_IF_flag) begin
                  req_nxt   = 1'b0;
                  state_nxt = IDLE;
                  if (jump_flag) begin
                     pc_nxt = jump_tgt;
                  end else begin
                     push   = 1'b1;
                     pc_nxt = pc + 32'd4;
                  end
               end else if (jump_flag) begin
                  // MC cannot abort: keep requesting, drop the word when it lands.
                  pc_nxt    = jump_tgt;
                  state_nxt = DISCARD;
               end
            end
            DISCARD: begin
               if (jump_flag) pc_nxt = jump_tgt;
               if (inst_IF_flag) begin
                  req_nxt   = 1'b0;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         inst_IF_addr <= RESET_PC;
         inst_IF_req  <= 1'b0;
      end else begin
         pc           <= pc_nxt;
         inst_IF_addr <= addr_nxt;
         inst_IF_req  <= req_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + (QUEUE_LOG+1)'(push) - (QUEUE_LOG+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[tail] <= inst_IF;
         pc_mem[tail]   <= inst_IF_addr;
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue: MC responder, queue-based reference model, per-cycle compare.
module tb_inst_fetch_queue;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b0;
   logic        inst_IF_flag = 1'b0;
   logic [31:0] inst_IF = '0;
   logic        jump_flag = 1'b0;
   logic [31:0] jump_pc = '0;
   logic        deq_ready = 1'b0;
   logic        inst_IF_req, deq_valid, queue_full;
   logic [31:0] inst_IF_addr, deq_inst, deq_pc;

   always #5 clk = ~clk;

   inst_fetch_queue dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .inst_IF_req(inst_IF_req), .inst_IF_addr(inst_IF_addr),
      .inst_IF_flag(inst_IF_flag), .inst_IF(inst_IF),
      .jump_flag(jump_flag), .jump_pc(jump_pc),
      .deq_ready(deq_ready), .deq_valid(deq_valid),
      .deq_inst(deq_inst), .deq_pc(deq_pc), .queue_full(queue_full)
   );

   int checks = 0;
   int failures = 0;

   // reference model: list of queued {inst, pc}, next pc, outstanding fetch and whether it is squashed
   logic [63:0] mq [$];
   logic [31:0] m_pc, m_addr;
   bit          m_busy, m_squash;
   logic [31:0] pop_log [$];
   int          jumps_seen = 0;

   // environment knobs
   int          mc_lat = 5, mc_cnt = 0;
   bit          flag_hold = 0;
   int          p_deq = 100, p_jump = 0, p_rdy = 100;
   int          jump_at_cnt = -1;
   bit          jump_on_flag = 0, jump_now = 0;
   logic [31:0] jump_tgt = '0;
   int          rdy_off = 0;
   bit          rdy_off_on_flag = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("req", 32'(inst_IF_req), 32'(m_busy));
      chk("addr", inst_IF_addr, m_addr);
      chk("deq_valid", 32'(deq_valid), 32'(mq.size() != 0));
      chk("queue_full", 32'(queue_full), 32'(mq.size() == 8));
      if (mq.size() != 0) begin
         chk("deq_pc", deq_pc, mq[0][31:0]);
         chk("deq_inst", deq_inst, mq[0][63:32]);
      end
   endtask

   task automatic drive();
      bit forced_off;
      forced_off = 0;
      if (m_busy) mc_cnt++; else mc_cnt = 0;
      if (flag_hold) inst_IF_flag = 1'b1;
      else if (m_busy && mc_cnt == mc_lat) begin
         inst_IF_flag = 1'b1;
         inst_IF = $urandom;
      end else inst_IF_flag = 1'b0;
      if (rdy_off > 0) begin
         rdy = 1'b0; rdy_off--; forced_off = 1;
      end else if (rdy_off_on_flag && inst_IF_flag) begin
         rdy = 1'b0; rdy_off = 2; rdy_off_on_flag = 0; forced_off = 1;
      end else rdy = ($urandom_range(99) < p_rdy);
      deq_ready = forced_off ? 1'b1 : ($urandom_range(99) < p_deq);
      jump_flag = 1'b0;
      jump_pc = $urandom;
      if (jump_now && rdy) begin
         jump_flag = 1'b1; jump_pc = jump_tgt; jump_now = 0;
      end else if (jump_on_flag && inst_IF_flag && rdy) begin
         jump_flag = 1'b1; jump_pc = jump_tgt; jump_on_flag = 0;
      end else if (jump_at_cnt > 0 && m_busy && mc_cnt == jump_at_cnt && rdy) begin
         jump_flag = 1'b1; jump_pc = jump_tgt; jump_at_cnt = -1;
      end else if ($urandom_range(99) < p_jump) jump_flag = 1'b1;
   endtask

   task automatic step();
      int n;
      bit pop, push, start;
      flag_hold = rst_n && inst_IF_flag && !rdy;
      if (!rst_n || !rdy) return;
      n     = mq.size();
      pop   = deq_ready && n != 0 && !jump_flag;
      push  = m_busy && inst_IF_flag && !m_squash && !jump_flag;
      start = !m_busy && !jump_flag && n < 8;
      if (pop) begin
         pop_log.push_back(mq[0][31:0]);
         void'(mq.pop_front());
      end
      if (push) begin
         mq.push_back({inst_IF, m_addr});
         m_pc = m_pc + 32'd4;
      end
      if (m_busy && inst_IF_flag) begin
         m_busy = 0; m_squash = 0;
      end else if (m_busy && jump_flag) m_squash = 1;
      if (jump_flag) begin
         mq.delete();
         m_pc = jump_pc & ~32'd3;
         jumps_seen++;
      end
      if (start) begin
         m_busy = 1; m_addr = m_pc;
      end
   endtask

   // Returns at a negedge with DUT and model describing the same state.
   task automatic cycle();
      drive();
      step();
      @(negedge clk);
      compare();
   endtask

   task automatic apply_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req", 32'(inst_IF_req), 32'd0);
      chk("rst_deq_valid", 32'(deq_valid), 32'd0);
      chk("rst_full", 32'(queue_full), 32'd0);
      chk("rst_addr", inst_IF_addr, 32'h0);
      mq.delete(); pop_log.delete();
      m_pc = 32'h0; m_addr = 32'h0; m_busy = 0; m_squash = 0;
      inst_IF_flag = 1'b0; flag_hold = 0; mc_cnt = 0;
      jump_now = 0; jump_at_cnt = -1; jump_on_flag = 0; rdy_off = 0; rdy_off_on_flag = 0;
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int k, j0;
      @(negedge clk);

      // 1: in-order fetch, words popped immediately
      apply_reset();
      mc_lat = 5; p_deq = 100; p_rdy = 100; p_jump = 0;
      for (k = 0; k < 300 && pop_log.size() < 3; k++) cycle();
      chk("t1_pops", 32'(pop_log.size()), 32'd3);
      chk("t1_pc0", pop_log[0], 32'h0);
      chk("t1_pc1", pop_log[1], 32'h4);
      chk("t1_pc2", pop_log[2], 32'h8);

      // 2: fill to full, then single pop
      apply_reset();
      p_deq = 0;
      for (k = 0; k < 300 && mq.size() < 8; k++) cycle();
      chk("t2_full", 32'(queue_full), 32'd1);
      repeat (5) cycle();
      chk("t2_req_idle", 32'(inst_IF_req), 32'd0);
      p_deq = 100; cycle(); p_deq = 0;
      chk("t2_not_full", 32'(queue_full), 32'd0);
      for (k = 0; k < 20 && !m_busy; k++) cycle();
      chk("t2_next_addr", inst_IF_addr, 32'h20);

      // 3: redirect while fetch of 0x8 is outstanding
      apply_reset();
      p_deq = 0;
      for (k = 0; k < 300 && !(m_busy && m_addr == 32'h8); k++) cycle();
      jump_at_cnt = 2; jump_tgt = 32'h100; j0 = jumps_seen;
      for (k = 0; k < 50 && jumps_seen == j0; k++) cycle();
      chk("t3_req_held", 32'(inst_IF_req), 32'd1);
      chk("t3_addr_held", inst_IF_addr, 32'h8);
      for (k = 0; k < 50 && m_busy; k++) cycle();
      chk("t3_discarded", 32'(deq_valid), 32'd0);
      for (k = 0; k < 50 && !m_busy; k++) cycle();
      chk("t3_new_addr", inst_IF_addr, 32'h100);
      for (k = 0; k < 50 && mq.size() == 0; k++) cycle();
      chk("t3_first_pc", deq_pc, 32'h100);

      // 4: redirect coincident with the returning word
      apply_reset();
      p_deq = 0;
      for (k = 0; k < 300 && mq.size() < 2; k++) cycle();
      jump_on_flag = 1; jump_tgt = 32'h203; j0 = jumps_seen;
      for (k = 0; k < 50 && jumps_seen == j0; k++) cycle();
      chk("t4_empty", 32'(deq_valid), 32'd0);
      chk("t4_req_low", 32'(inst_IF_req), 32'd0);
      for (k = 0; k < 50 && !m_busy; k++) cycle();
      chk("t4_new_addr", inst_IF_addr, 32'h200);

      // 5: rdy low for three cycles while the word returns and decode wants to pop
      apply_reset();
      p_deq = 0;
      for (k = 0; k < 300 && mq.size() < 2; k++) cycle();
      rdy_off_on_flag = 1;
      for (k = 0; k < 100 && mq.size() < 3; k++) cycle();
      chk("t5_head_kept", deq_pc, 32'h0);
      p_deq = 100;
      for (k = 0; k < 100 && pop_log.size() < 3; k++) cycle();
      chk("t5_third_pc", pop_log[2], 32'h8);

      // 6: asynchronous reset with five entries queued and a fetch outstanding
      apply_reset();
      p_deq = 0;
      for (k = 0; k < 300 && !(mq.size() == 5 && m_busy); k++) cycle();
      chk("t6_pre_valid", 32'(deq_valid), 32'd1);
      apply_reset();
      for (k = 0; k < 20 && !m_busy; k++) cycle();
      chk("t6_restart_addr", inst_IF_addr, 32'h0);

      // PC wraps modulo 2^32
      apply_reset();
      p_deq = 100; jump_now = 1; jump_tgt = 32'hFFFF_FFFC;
      for (k = 0; k < 100 && !(m_busy && m_addr == 32'hFFFF_FFFC); k++) cycle();
      for (k = 0; k < 100 && !(m_busy && m_addr != 32'hFFFF_FFFC); k++) cycle();
      chk("wrap_addr", inst_IF_addr, 32'h0);

      // random traffic
      apply_reset();
      p_rdy = 85; p_jump = 3; p_deq = 50;
      for (int i = 0; i < 4000; i++) begin
         if (!m_busy && !flag_hold && (i % 50) == 0) mc_lat = $urandom_range(6, 1);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
